// File: rtl/ps2_rx_if.sv
// Output bundle of the PS/2 receiver toward the scan-code-to-note decoder.
// The receiver drives it through the master modport; the decoder reads it through the slave modport.
interface ps2_rx_if;
  logic [7:0] code;
  logic       code_valid;
  logic       idle;
  logic       frame_err;

  modport master (output code, output code_valid, output idle, output frame_err);
  modport slave  (input  code, input  code_valid, input  idle, input  frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and filters the pins, deserializes
// 11-bit frames, and presents good scan codes with an idle flag; errors and stalls force idle.
module ps2_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic     clk_50Mhz,
  input  logic     rst_n,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  ps2_rx_if.master rx
);

  localparam int unsigned TMO_W  = 16;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned CODE_W = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  logic                  clk_meta_q, clk_sync_q;
  logic                  dat_meta_q, dat_sync_q;
  logic [FILTER_LEN-1:0] filt_sh_q, filt_sh_d;
  logic                  filt_q, filt_d;
  logic                  sample_c;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CODE_W-1:0]     shift_q, shift_d;
  logic                  par_ok_q, par_ok_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  tmo_hit_c;
  logic                  good_c, err_c;

  logic [CODE_W-1:0]     code_q, code_d;
  logic                  code_valid_q, code_valid_d;
  logic                  idle_q, idle_d;
  logic                  frame_err_q, frame_err_d;

  // Glitch filter: level changes only after FILTER_LEN identical synced samples.
  always_comb begin
    filt_sh_d = {filt_sh_q[FILTER_LEN-2:0], clk_sync_q};
    filt_d    = filt_q;
    if (&filt_sh_q) begin
      filt_d = 1'b1;
    end else if (~|filt_sh_q) begin
      filt_d = 1'b0;
    end
  end

  assign sample_c  = filt_q & ~|filt_sh_q;
  assign tmo_hit_c = (tmo_q == TMO_LAST);

  // Frame FSM; a sample event in the timeout cycle takes priority over the abort.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    good_c    = 1'b0;
    err_c     = 1'b0;
    tmo_d     = (state_q == ST_IDLE || sample_c) ? '0 : tmo_q + TMO_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (sample_c && !dat_sync_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (sample_c) begin
          shift_d[bit_cnt_q] = dat_sync_q;
          bit_cnt_d          = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(CODE_W - 1)) begin
            state_d = ST_PARITY;
          end
        end else if (tmo_hit_c) begin
          state_d = ST_IDLE;
          err_c   = 1'b1;
        end
      end
      ST_PARITY: begin
        if (sample_c) begin
          par_ok_d = ^{shift_q, dat_sync_q};
          state_d  = ST_STOP;
        end else if (tmo_hit_c) begin
          state_d = ST_IDLE;
          err_c   = 1'b1;
        end
      end
      ST_STOP: begin
        if (sample_c) begin
          state_d = ST_IDLE;
          if (par_ok_q && dat_sync_q) begin
            good_c = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end else if (tmo_hit_c) begin
          state_d = ST_IDLE;
          err_c   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Held code / idle flag and one-cycle strobes.
  always_comb begin
    code_d       = code_q;
    idle_d       = idle_q;
    code_valid_d = good_c;
    frame_err_d  = err_c;
    if (good_c) begin
      code_d = shift_q;
      idle_d = 1'b0;
    end else if (err_c) begin
      code_d = '0;
      idle_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q   <= 1'b1;
      clk_sync_q   <= 1'b1;
      dat_meta_q   <= 1'b1;
      dat_sync_q   <= 1'b1;
      filt_sh_q    <= {FILTER_LEN{1'b1}};
      filt_q       <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      tmo_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      idle_q       <= 1'b1;
      frame_err_q  <= 1'b0;
    end else begin
      clk_meta_q   <= ps2_clk;
      clk_sync_q   <= clk_meta_q;
      dat_meta_q   <= ps2_data;
      dat_sync_q   <= dat_meta_q;
      filt_sh_q    <= filt_sh_d;
      filt_q       <= filt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      tmo_q        <= tmo_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      idle_q       <= idle_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx.code       = code_q;
  assign rx.code_valid = code_valid_q;
  assign rx.idle       = idle_q;
  assign rx.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of frames with expected code/strobes, plus stall,
// glitch and mid-frame reset sequences. Short TIMEOUT and fast PS/2 clock keep runs small.
module tb_ps2_rx;
  localparam int unsigned L    = 8;
  localparam int unsigned T    = 200;
  localparam int unsigned HALF = 25;

  logic clk, rst_n, ps2_clk, ps2_data;
  ps2_rx_if bus ();

  ps2_rx #(.FILTER_LEN(L), .TIMEOUT(T)) dut (
    .clk_50Mhz(clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int strobe_viol = 0;
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;

  // Strobe counting and strobe-rule tracking, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.code_valid) valid_cnt++;
    if (bus.frame_err)  err_cnt++;
    if (bus.code_valid && bus.frame_err) strobe_viol++;
    if ((bus.code_valid && prev_valid) || (bus.frame_err && prev_err)) strobe_viol++;
    prev_valid = bus.code_valid;
    prev_err   = bus.frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(14);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 17);
    end else begin
      wait_cyc(HALF);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop, input bit glitch);
    logic par;
    par = ~^b ^ flip_par;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, glitch);
    ps2_data = 1'b1;
    wait_cyc(10);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         flip_par;
    logic       stop;
    bit         glitch;
    logic [7:0] exp_code;
    int         exp_valid;
    int         exp_err;
    logic       exp_idle;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int hit;
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1, 0, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'hF0, 1, 0, 1'b0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1, 0, 1'b0};
    vecs[3] = '{8'h23, 1'b0, 1'b1, 1'b0, 8'h23, 1, 0, 1'b0};
    vecs[4] = '{8'h2B, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1, 1'b1};
    vecs[5] = '{8'h42, 1'b0, 1'b1, 1'b0, 8'h42, 1, 0, 1'b0};
    vecs[6] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 1'b1};
    vecs[7] = '{8'h3A, 1'b0, 1'b1, 1'b1, 8'h3A, 1, 0, 1'b0};
    vecs[8] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1, 0, 1'b0};
    vecs[9] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1, 0, 1'b0};

    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    chk("rst_code",  32'(bus.code), 32'h00);
    chk("rst_idle",  32'(bus.idle), 32'h1);
    rst_n = 1'b1;
    wait_cyc(20);
    chk("post_rst_valid", 32'(bus.code_valid), 32'h0);
    chk("post_rst_err",   32'(bus.frame_err), 32'h0);
    chk("post_rst_idle",  32'(bus.idle), 32'h1);

    foreach (vecs[k]) begin
      if (vecs[k].glitch) begin
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(3);
        ps2_clk  = 1'b1;
        wait_cyc(15);
        ps2_data = 1'b1;
        wait_cyc(5);
      end
      valid_cnt = 0;
      err_cnt   = 0;
      send_frame(vecs[k].data, vecs[k].flip_par, vecs[k].stop, vecs[k].glitch);
      chk($sformatf("v%0d_code", k),  32'(bus.code), 32'(vecs[k].exp_code));
      chk($sformatf("v%0d_idle", k),  32'(bus.idle), 32'(vecs[k].exp_idle));
      chk($sformatf("v%0d_valid", k), 32'(valid_cnt), 32'(vecs[k].exp_valid));
      chk($sformatf("v%0d_err", k),   32'(err_cnt), 32'(vecs[k].exp_err));
    end

    // Stalled frame: start plus four data bits, then the clock stays high.
    err_cnt = 0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(5);
    ps2_clk = 1'b0;
    hit = 0;
    for (int i = 1; i <= 400 && hit == 0; i++) begin
      tick();
      if (i == int'(HALF)) ps2_clk = 1'b1;
      if (bus.frame_err) hit = i;
    end
    ps2_clk = 1'b1;
    chk("stall_latency", 32'(hit), 32'(L + T + 3));
    wait_cyc(5);
    chk("stall_code", 32'(bus.code), 32'h00);
    chk("stall_idle", 32'(bus.idle), 32'h1);
    chk("stall_errs", 32'(err_cnt), 32'h1);
    valid_cnt = 0;
    send_frame(8'h1B, 1'b0, 1'b1, 1'b0);
    chk("after_stall_code",  32'(bus.code), 32'h1B);
    chk("after_stall_valid", 32'(valid_cnt), 32'h1);
    chk("after_stall_idle",  32'(bus.idle), 32'h0);

    // Reset after five data bits.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_code",  32'(bus.code), 32'h00);
    chk("midrst_idle",  32'(bus.idle), 32'h1);
    chk("midrst_valid", 32'(bus.code_valid), 32'h0);
    chk("midrst_err",   32'(bus.frame_err), 32'h0);
    ps2_data = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(20);
    valid_cnt = 0;
    err_cnt   = 0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("after_rst_code",  32'(bus.code), 32'h3C);
    chk("after_rst_valid", 32'(valid_cnt), 32'h1);
    chk("after_rst_err",   32'(err_cnt), 32'h0);
    chk("after_rst_idle",  32'(bus.idle), 32'h0);

    chk("strobe_rules", 32'(strobe_viol), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
